bcd_seg_scanner: RTL and testbench
==================================

# bcd_seg_scanner

Display-side reader for the ALU lab datapath. It samples an 8-bit operand or result on request and converts it to BCD with a sequential double-dabble engine. It then drives a 4-digit, common-anode seven-segment display by time-multiplexing the digits. It sits between the register/ALU stage and the board display pins.

## Interface
- REFRESH_DIV, default 100000: clk cycles each digit stays lit; legal range ≥2.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- value  in  8  byte to display; sampled only on an accepted load.
- signed_mode  in  1  when 1, treat value as two's complement; sampled with value.
- load  in  1  single-cycle request to sample and convert value.
- busy  out  1  conversion in progress; load is ignored while high.
- anode  out  4  digit enables, active-low, one-hot-zero (0 = lit).
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low; constant 1 (off).

## Operation
- FSM states: IDLE, CONV, DONE.
  - IDLE: on load=1, capture value and signed_mode, then go to CONV.
  - CONV: 8 iterations, one per cycle. Apply add-3 to each BCD nibble ≥5, then shift the 12-bit BCD register and 8-bit shift register left by 1.
  - DONE: copy BCD nibbles and the sign flag into display registers, then return to IDLE.
- Magnitude rule: if signed_mode=1 and value[7]=1, convert the 8-bit two's-complement magnitude (0 - value). Example: -128 gives 8'h80, shown as 128. Otherwise convert value unsigned (0..255).
- Digit map:
  - digit0 (rightmost, anode[0]) = ones.
  - digit1 = tens.
  - digit2 = hundreds.
  - digit3 = '-' if the sign flag is set, else blank.
- Glyphs (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - '-'=0111111; blank=1111111.
  - Nibble values 10..15 cannot occur; map them to blank.
- Scanner:
  - A free-running counter counts 0..REFRESH_DIV-1 and is independent of the FSM.
  - On wrap, the digit index advances 0→1→2→3→0.
  - anode for index i is all ones except bit i.
- Boundaries:
  - load while busy: ignored, with no queueing.
  - load in the same cycle busy falls (DONE): ignored.
  - value changing during CONV: no effect, since it was captured at accept.
  - Reset mid-conversion: abort, clear display registers, FSM to IDLE, busy=0.

## Timing
- Reset values:
  - FSM = IDLE, busy = 0, display registers = 0, sign = 0.
  - Refresh counter = 0, digit index = 0.
  - Outputs: anode = 4'b1110, seg = 1000000 ('0'), dp = 1.
- Accept: load=1 with busy=0 at edge k. busy is 1 from edge k through edge k+9 (8 CONV + 1 DONE cycles), then 0 after edge k+9.
- Display registers update at edge k+9. seg and anode are registered and reflect the new digit one cycle later (k+10), provided the lit digit is affected.
- Minimum load-to-load spacing is 10 cycles.
- Scanning:
  - anode and seg change together, at the same edge the index advances.
  - Each digit is lit for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
  - No glitch cycle with two anodes low.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN:
  - Defined:
    - The hundreds digit is blank when hundreds=0.
    - The tens digit is blank when hundreds=0 and tens=0.
    - The ones digit is always shown.
    - '-' stays in digit3, not adjacent to the number.
  - Undefined: all three numeric digits are always shown, e.g. 007.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, release → anode=1110, seg=1000000, dp=1, busy=0.
- Unsigned convert: signed_mode=0, value=8'd255, load pulse, REFRESH_DIV=4 → busy high for 9 cycles. Over one frame: digit0=0010010 (5), digit1=0010010 (5), digit2=0100100 (2), digit3=1111111.
- Signed minimum: signed_mode=1, value=8'h80 → digits 8, 2, 1 and digit3=0111111 ('-'). Then value=8'hFF → 1, 0, 0 with '-'.
- Busy collision: load value=8'd12, then load value=8'd99 at cycle +3 → display shows 012 (or blank/blank/2 with the macro). busy falls exactly 9 cycles after the first accept.
- Reset mid-conversion: load 8'd200, assert rst_n=0 at CONV iteration 4 → next cycle busy=0, display 000, anode=1110.
- Leading-zero macro: value=8'd7, REFRESH_DIV=2, compiled both ways → defined: digit1/digit2=1111111; undefined: digit1/digit2=1000000. Anode rotation period is 8 cycles in both builds.

Source files
------------

// File: rtl/bcd_seg_scanner_if.sv
// Display-side port bundle for bcd_seg_scanner: load/busy request channel plus
// the seven-segment pin outputs and an FSM state debug tap.
interface bcd_seg_scanner_if;
  logic [7:0] value;
  logic       signed_mode;
  logic       load;
  logic       busy;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] state_dbg;

  modport master (
    output value, signed_mode, load,
    input  busy, anode, seg, dp, state_dbg
  );

  modport slave (
    input  value, signed_mode, load,
    output busy, anode, seg, dp, state_dbg
  );
endinterface

// File: rtl/bcd_seg_scanner.sv
// Samples a byte, converts it to BCD with a sequential double-dabble, and scans
// it onto a 4-digit common-anode display. Optional macro: SEG_LEADING_ZERO_BLANK_EN.
module bcd_seg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input logic             clk,
  input logic             rst_n,
  bcd_seg_scanner_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] GL_BLANK = 7'b1111111;
  localparam logic [6:0] GL_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  // Handshake: a request is accepted on a clock edge where load=1 and busy=0;
  // busy then stays high until the result is on the display registers, and
  // any load seen while busy is dropped, not queued.
  state_t      state;
  logic        busy;
  logic [11:0] bcd;
  logic [7:0]  sr;
  logic [2:0]  iter;
  logic        sign_cap;
  logic [3:0]  ones, tens, hund;
  logic        sign;

  logic       neg;
  logic [7:0] mag;
  logic [3:0] adj_o, adj_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    neg   = bus.signed_mode & bus.value[7];
    mag   = neg ? (~bus.value + 8'd1) : bus.value;
    adj_o = add3(bcd[3:0]);
    adj_t = add3(bcd[7:4]);
  end

  // Hundreds never exceeds 2 for an 8-bit input, so it needs no add-3 step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      bcd      <= '0;
      sr       <= '0;
      iter     <= '0;
      sign_cap <= 1'b0;
      ones     <= '0;
      tens     <= '0;
      hund     <= '0;
      sign     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            sr       <= mag;
            sign_cap <= neg;
            bcd      <= '0;
            iter     <= '0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          {bcd, sr} <= {bcd[10:8], adj_t, adj_o, sr, 1'b0};
          iter      <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
        end
        DONE: begin
          hund  <= bcd[11:8];
          tens  <= bcd[7:4];
          ones  <= bcd[3:0];
          sign  <= sign_cap;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return GL_BLANK;
    endcase
  endfunction

  logic [CW-1:0] rcnt;
  logic [1:0]    idx, idx_nxt;
  logic          wrap, blank_h, blank_t;
  logic [6:0]    seg_nxt;
  logic [3:0]    anode_r;
  logic [6:0]    seg_r;

  always_comb begin
    wrap    = (rcnt == CW'(REFRESH_DIV - 1));
    idx_nxt = wrap ? idx + 2'd1 : idx;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank_h = (hund == 4'd0);
    blank_t = (hund == 4'd0) && (tens == 4'd0);
`else
    blank_h = 1'b0;
    blank_t = 1'b0;
`endif
    seg_nxt = GL_BLANK;
    case (idx_nxt)
      2'd0: seg_nxt = glyph(ones);
      2'd1: seg_nxt = blank_t ? GL_BLANK : glyph(tens);
      2'd2: seg_nxt = blank_h ? GL_BLANK : glyph(hund);
      2'd3: seg_nxt = sign ? GL_DASH : GL_BLANK;
      default: seg_nxt = GL_BLANK;
    endcase
  end

  // anode and seg are driven from the next index so both move on the wrap edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt    <= '0;
      idx     <= '0;
      anode_r <= 4'b1110;
      seg_r   <= 7'b1000000;
    end else begin
      rcnt    <= wrap ? '0 : rcnt + CW'(1);
      idx     <= idx_nxt;
      anode_r <= ~(4'b0001 << idx_nxt);
      seg_r   <= seg_nxt;
    end
  end

  assign bus.busy      = busy;
  assign bus.anode     = anode_r;
  assign bus.seg       = seg_r;
  assign bus.dp        = 1'b1;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Randomized bench for bcd_seg_scanner: arithmetic reference model checked every
// cycle, plus literal frame checks. Honors SEG_LEADING_ZERO_BLANK_EN.
module tb_bcd_seg_scanner;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_seg_scanner_if bus();
  bcd_seg_scanner #(.REFRESH_DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BLANK;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [6:0] exp_q[$];
  logic [6:0] frame [4];
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal digits from division, scan position from the
  // count of clock edges since reset, busy as a 9-cycle countdown.
  int t, idx, busy_left, pend_mag, disp_mag;
  bit pend_neg, disp_neg;
  logic       exp_busy;
  logic [3:0] exp_anode;
  logic [6:0] exp_seg;

  function automatic logic [6:0] model_glyph(input int d, input int mag, input bit neg);
    int h, tn, o;
    h  = mag / 100;
    tn = (mag / 10) % 10;
    o  = mag % 10;
    case (d)
      0: return GLYPH[o];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      1: return (h == 0 && tn == 0) ? BLANK : GLYPH[tn];
      2: return (h == 0) ? BLANK : GLYPH[h];
`else
      1: return GLYPH[tn];
      2: return GLYPH[h];
`endif
      default: return neg ? DASH : BLANK;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0; busy_left = 0; disp_mag = 0; disp_neg = 1'b0;
      exp_busy = 1'b0; exp_anode = 4'b1110; exp_seg = GLYPH[0];
    end else begin
      t = t + 1;
      idx = (t / DIV) % 4;
      exp_anode = ~(4'b0001 << idx);
      exp_seg = model_glyph(idx, disp_mag, disp_neg);
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
        if (busy_left == 0) begin
          disp_mag = pend_mag;
          disp_neg = pend_neg;
        end
      end else if (bus.load) begin
        busy_left = 9;
        pend_neg = bus.signed_mode && bus.value[7];
        pend_mag = pend_neg ? 256 - int'(bus.value) : int'(bus.value);
      end
      exp_busy = (busy_left > 0);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("busy", bus.busy, exp_busy);
      check("anode", bus.anode, exp_anode);
      check("seg", bus.seg, exp_seg);
      check("dp", bus.dp, 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v, input logic s);
    bus.value = v;
    bus.signed_mode = s;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic busy_len(input string name, input int exp_len);
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check(name, cnt, exp_len);
  endtask

  task automatic capture_frame(input string name);
    logic [6:0] e;
    for (int i = 0; i < 4; i++) frame[i] = 7'bx;
    repeat (4 * DIV) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (bus.anode == ~(4'b0001 << i)) frame[i] = bus.seg;
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_d%0d", name, i), frame[i], e);
    end
  endtask

  task automatic push4(input logic [6:0] d0, input logic [6:0] d1,
                       input logic [6:0] d2, input logic [6:0] d3);
    exp_q.push_back(d0); exp_q.push_back(d1);
    exp_q.push_back(d2); exp_q.push_back(d3);
  endtask

  task automatic anode_entry(output int n, output bit ok);
    logic [3:0] prev;
    prev = bus.anode;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.anode == 4'b1110 && prev != 4'b1110) ok = 1'b1;
      prev = bus.anode;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap;
    bit ok;
    bus.value = '0;
    bus.signed_mode = 1'b0;
    bus.load = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_anode", bus.anode, 4'b1110);
    check("rst_seg", bus.seg, 7'b1000000);
    check("rst_dp", bus.dp, 1'b1);
    check_en = 1'b1;

    do_load(8'd255, 1'b0);
    busy_len("busy_len_255", 9);
    tick(1);
    push4(7'b0010010, 7'b0010010, 7'b0100100, 7'b1111111);
    capture_frame("u255");

    do_load(8'h80, 1'b1);
    busy_len("busy_len_m128", 9);
    tick(1);
    push4(7'b0000000, 7'b0100100, 7'b1111001, 7'b0111111);
    capture_frame("m128");

    do_load(8'hFF, 1'b1);
    tick(12);
    push4(7'b1111001, LZ, LZ, 7'b0111111);
    capture_frame("m1");

    do_load(8'd12, 1'b0);
    tick(2);
    do_load(8'd99, 1'b0);
    busy_len("busy_collide", 6);
    tick(1);
    push4(7'b0100100, 7'b1111001, LZ, 7'b1111111);
    capture_frame("collide");

    do_load(8'd200, 1'b0);
    tick(3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_anode", bus.anode, 4'b1110);
    check("midrst_seg", bus.seg, 7'b1000000);
    rst_n = 1'b1;
    push4(7'b1000000, LZ, LZ, 7'b1111111);
    capture_frame("midrst");

    do_load(8'd7, 1'b0);
    tick(12);
    push4(7'b1111000, LZ, LZ, 7'b1111111);
    capture_frame("lz7");
    anode_entry(n, ok);
    check("anode_sync", ok, 1'b1);
    anode_entry(n, ok);
    check("anode_period", n, 4 * DIV);

    for (int r = 0; r < 40; r++) begin
      do_load(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      gap = $urandom_range(1, 14);
      repeat (gap) begin
        bus.load = ($urandom_range(0, 3) == 0);
        bus.value = 8'($urandom);
        bus.signed_mode = 1'($urandom);
        @(negedge clk);
      end
      bus.load = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) tick(4 * DIV + 10);
    end
    tick(4 * DIV + 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
